// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE operand bits per clock pass
// through a ripple chain of full adders; the carry is held between cycles.
// Subtraction is A + ~B + 1. Results update only when entering DONE.
module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state;
  state_t                          state_nxt;
  logic [WIDTH-1:0]                sh_a;
  logic [WIDTH-1:0]                sh_b;
  logic [WIDTH-1:0]                sh_s;
  logic                            carry;
  logic [CW-1:0]                   count;
  logic [BITS_PER_CYCLE-1:0]       psum;
  logic                            ripple_c;
  logic                            c_top;
  logic                            c_out;
  logic [WIDTH+BITS_PER_CYCLE-1:0] s_cat;
  logic [WIDTH-1:0]                s_next;
  logic                            last_step;
  logic                            accept;

  assign last_step = (count == CW'(STEPS - 1));
  assign accept    = i_start && ((state == IDLE) || (state == DONE));

  // New partial sum enters at the MSB end; concatenation keeps this legal
  // when one step covers the whole word (BITS_PER_CYCLE == WIDTH).
  assign s_cat  = {psum, sh_s};
  assign s_next = s_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];

  // Ripple chain over the low slice; c_top is the carry into the slice's top bit
  always_comb begin
    ripple_c = carry;
    c_top    = carry;
    psum     = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      c_top    = ripple_c;
      psum[i]  = sh_a[i] ^ sh_b[i] ^ ripple_c;
      ripple_c = (sh_a[i] & sh_b[i]) | (ripple_c & (sh_a[i] ^ sh_b[i]));
    end
    c_out = ripple_c;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = i_start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    o_busy = (state == RUN);
    o_done = (state == DONE);
  end

  // Operand load, per-step shift/accumulate, result capture on the final step
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      sh_s   <= '0;
      carry  <= 1'b0;
      count  <= '0;
      o_sum  <= '0;
      o_cout <= 1'b0;
      o_ovf  <= 1'b0;
    end else if (accept) begin
      sh_a  <= i_a;
      sh_b  <= i_sub ? ~i_b : i_b;
      carry <= i_sub ? 1'b1 : i_cin;
      count <= '0;
    end else if (state == RUN) begin
      sh_a  <= sh_a >> BITS_PER_CYCLE;
      sh_b  <= sh_b >> BITS_PER_CYCLE;
      sh_s  <= s_next;
      carry <= c_out;
      count <= count + CW'(1);
      if (last_step) begin
        o_sum  <= s_next;
        o_cout <= c_out;
        o_ovf  <= c_top ^ c_out;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder in three configurations:
// 1-bit registered full adder, 8-bit bit-serial, 16-bit nibble-serial.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // WIDTH=1, BPC=1
  logic       start1 = 0, a1 = 0, b1 = 0, cin1 = 0, sub1 = 0;
  logic       busy1, done1, sum1, cout1, ovf1;
  // WIDTH=8, BPC=1
  logic       start8 = 0, cin8 = 0, sub8 = 0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       busy8, done8, cout8, ovf8;
  // WIDTH=16, BPC=4
  logic        start16 = 0, cin16 = 0, sub16 = 0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        busy16, done16, cout16, ovf16;

  serial_adder #(.WIDTH(1), .BITS_PER_CYCLE(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_a(a1), .i_b(b1),
    .i_cin(cin1), .i_sub(sub1), .o_busy(busy1), .o_done(done1),
    .o_sum(sum1), .o_cout(cout1), .o_ovf(ovf1));

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_a(a8), .i_b(b8),
    .i_cin(cin8), .i_sub(sub8), .o_busy(busy8), .o_done(done8),
    .o_sum(sum8), .o_cout(cout8), .o_ovf(ovf8));

  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start16), .i_a(a16), .i_b(b16),
    .i_cin(cin16), .i_sub(sub16), .o_busy(busy16), .o_done(done16),
    .o_sum(sum16), .o_cout(cout16), .o_ovf(ovf16));

  // One 1-bit operation; lat = edges from start edge to done
  task automatic run1(input logic a, b, cin, output logic s, co, output int lat);
    int n;
    @(negedge clk); a1 = a; b1 = b; cin1 = cin; sub1 = 0; start1 = 1;
    @(negedge clk); start1 = 0; n = 1;
    while (!done1 && n < 20) begin @(negedge clk); n++; end
    lat = n - 1; s = sum1; co = cout1;
  endtask

  // One 8-bit operation; also counts sampled cycles with busy high
  task automatic run8(input logic [7:0] a, b, input logic cin, sub,
                      output logic [7:0] s, output logic co, ov,
                      output int lat, output int busy);
    int n;
    @(negedge clk); a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1;
    @(negedge clk); start8 = 0; n = 1; busy = busy8 ? 1 : 0;
    while (!done8 && n < 40) begin
      @(negedge clk); n++;
      if (busy8) busy++;
    end
    lat = n - 1; s = sum8; co = cout8; ov = ovf8;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({sum8, cout8, ovf8, busy8, done8} !== 12'h000) begin
      errors++;
      $display("FAIL reset_u8 got %h exp 000", {sum8, cout8, ovf8, busy8, done8});
    end
    checks++;
    if ({sum16, cout16, ovf16, busy16, done16, sum1, cout1, ovf1, busy1, done1} !== 25'h0) begin
      errors++;
      $display("FAIL reset_u16_u1 got %h exp 0",
               {sum16, cout16, ovf16, busy16, done16, sum1, cout1, ovf1, busy1, done1});
    end
    rst_n = 1;
  endtask

  task automatic test_full_adder;
    logic [1:0] exp_tab [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    logic [2:0] v;
    logic s, co;
    int lat;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      run1(v[2], v[1], v[0], s, co, lat);
      checks++;
      if ({co, s} !== exp_tab[i]) begin
        errors++;
        $display("FAIL fa_result abc=%b got %b exp %b", v, {co, s}, exp_tab[i]);
      end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL fa_latency abc=%b got %0d exp 1", v, lat);
      end
    end
  endtask

  task automatic test_basic_add;
    logic [7:0] s; logic co, ov; int lat, busy;
    run8(8'h5A, 8'h33, 1'b0, 1'b0, s, co, ov, lat, busy);
    checks++;
    if ({co, ov, s} !== {1'b0, 1'b1, 8'h8D}) begin
      errors++;
      $display("FAIL add_5a_33 got %h exp %h", {co, ov, s}, {1'b0, 1'b1, 8'h8D});
    end
    checks++;
    if (lat != 8) begin errors++; $display("FAIL add_latency got %0d exp 8", lat); end
    checks++;
    if (busy != 8) begin errors++; $display("FAIL busy_cycles got %0d exp 8", busy); end
  endtask

  task automatic test_boundaries;
    logic [7:0] va [3] = '{8'hFF, 8'h10, 8'h80};
    logic [7:0] vb [3] = '{8'h01, 8'h20, 8'h01};
    logic       vs [3] = '{1'b0, 1'b1, 1'b1};
    logic [9:0] ve [3] = '{{1'b1, 1'b0, 8'h00}, {1'b0, 1'b0, 8'hF0}, {1'b1, 1'b1, 8'h7F}};
    logic [7:0] s; logic co, ov; int lat, busy;
    for (int i = 0; i < 3; i++) begin
      run8(va[i], vb[i], 1'b0, vs[i], s, co, ov, lat, busy);
      checks++;
      if ({co, ov, s} !== ve[i]) begin
        errors++;
        $display("FAIL boundary_%0d got %h exp %h", i, {co, ov, s}, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    // start pulse during RUN must be ignored
    @(negedge clk); a8 = 8'h12; b8 = 8'h34; cin8 = 0; sub8 = 0; start8 = 1;
    @(negedge clk); start8 = 0; n = 1;
    @(negedge clk); @(negedge clk); n = 3;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1;
    @(negedge clk); start8 = 0; n = 4;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (sum8 !== 8'h46) begin errors++; $display("FAIL midrun_start_sum got %h exp 46", sum8); end
    checks++;
    if (n - 1 != 8) begin errors++; $display("FAIL midrun_start_latency got %0d exp 8", n - 1); end
    // start held high through DONE
    @(negedge clk); a8 = 8'h01; b8 = 8'h02; start8 = 1; n = 0;
    while (!done8 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (sum8 !== 8'h03) begin errors++; $display("FAIL held_first_sum got %h exp 03", sum8); end
    a8 = 8'h10; n = 0;
    do begin @(negedge clk); n++; end while (!done8 && n < 40);
    start8 = 0;
    checks++;
    if (n != 9) begin errors++; $display("FAIL held_gap got %0d exp 9", n); end
    checks++;
    if (sum8 !== 8'h12) begin errors++; $display("FAIL held_second_sum got %h exp 12", sum8); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    logic seen;
    logic [7:0] s; logic co, ov; int lat, busy;
    @(negedge clk); a8 = 8'h0F; b8 = 8'h01; cin8 = 0; sub8 = 0; start8 = 1;
    @(negedge clk); start8 = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 0; #1;
    checks++;
    if ({sum8, cout8, ovf8, busy8, done8} !== 12'h000) begin
      errors++;
      $display("FAIL midrun_reset_outputs got %h exp 000", {sum8, cout8, ovf8, busy8, done8});
    end
    seen = 0;
    repeat (3) begin @(negedge clk); if (done8) seen = 1; end
    rst_n = 1;
    repeat (12) begin @(negedge clk); if (done8) seen = 1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL midrun_reset_no_done got %b exp 0", seen); end
    run8(8'h0F, 8'h01, 1'b0, 1'b0, s, co, ov, lat, busy);
    checks++;
    if ({co, ov, s} !== {2'b00, 8'h10} || lat != 8) begin
      errors++;
      $display("FAIL after_reset_op got %h lat %0d exp 010 lat 8", {co, ov, s}, lat);
    end
  endtask

  task automatic test_random16;
    logic [15:0] a, b, bb, prev;
    logic        cin, sub, ovf_exp, stable;
    logic [16:0] exp_v;
    int n;
    for (int k = 0; k < 1000; k++) begin
      a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      bb = sub ? ~b : b;
      exp_v = {1'b0, a} + {1'b0, bb} + 17'(sub ? 1'b1 : cin);
      ovf_exp = (a[15] == bb[15]) && (exp_v[15] != a[15]);
      prev = sum16; stable = 1;
      @(negedge clk); a16 = a; b16 = b; cin16 = cin; sub16 = sub; start16 = 1;
      @(negedge clk); start16 = 0; n = 1;
      a16 = 16'($urandom); b16 = 16'($urandom);
      if (!done16 && sum16 !== prev) stable = 0;
      while (!done16 && n < 20) begin
        @(negedge clk); n++;
        if (!done16 && sum16 !== prev) stable = 0;
      end
      checks++;
      if ({cout16, sum16} !== exp_v) begin
        errors++;
        $display("FAIL rnd_sum #%0d a=%h b=%h cin=%b sub=%b got %h exp %h",
                 k, a, b, cin, sub, {cout16, sum16}, exp_v);
      end
      checks++;
      if (ovf16 !== ovf_exp) begin
        errors++;
        $display("FAIL rnd_ovf #%0d a=%h b=%h sub=%b got %b exp %b", k, a, b, sub, ovf16, ovf_exp);
      end
      checks++;
      if (n - 1 != 4) begin errors++; $display("FAIL rnd_latency #%0d got %0d exp 4", k, n - 1); end
      checks++;
      if (stable !== 1'b1) begin errors++; $display("FAIL rnd_sum_stable #%0d got %b exp 1", k, stable); end
    end
  endtask

  initial begin
    test_reset();
    test_full_adder();
    test_basic_add();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_run();
    test_random16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
